// File: rtl/ascon_pkg.sv
// Shared types, constants and helper functions for the Ascon permutation.
// - t_state_array : 5 x 64-bit state, word index w holds x_w.
// - t_perm_fsm    : permutation controller states.
// - round_const() : 8-bit round constant c[r] = {15-r, r}.
// - sbox5()       : 5-bit Ascon S-box, input/output bit 4 = x0 ... bit 0 = x4.
// - ror64()       : 64-bit rotate right.
// - legal_rounds(): accepted round counts for a given unroll factor.
package ascon_pkg;

    localparam int unsigned C_WORD_WIDTH = 64;
    localparam int unsigned C_NUM_WORDS  = 5;
    localparam int unsigned C_MAX_ROUNDS = 12;

    typedef logic [C_WORD_WIDTH-1:0]  t_word;
    typedef t_word [C_NUM_WORDS-1:0]  t_state_array;

    typedef enum logic {
        IDLE,
        RUN
    } t_perm_fsm;

    // Linear-layer rotation amounts, indexed by word.
    localparam int unsigned C_ROT_A [C_NUM_WORDS] = '{19, 61, 1, 10, 7};
    localparam int unsigned C_ROT_B [C_NUM_WORDS] = '{28, 39, 6, 17, 41};

    localparam logic [4:0] C_SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'(4'hF - r), r};
    endfunction

    function automatic logic [4:0] sbox5(input logic [4:0] v);
        return C_SBOX[v];
    endfunction

    function automatic t_word ror64(input t_word x, input int unsigned k);
        return (x >> k) | (x << (C_WORD_WIDTH - k));
    endfunction

    // With two rounds per cycle the count must also be even.
    function automatic logic legal_rounds(input logic [3:0] n, input int unsigned g);
        return ((n == 4'd6) || (n == 4'd8) || (n == 4'd12)) && !((g == 2) && n[0]);
    endfunction

endpackage

// File: rtl/ascon_permutation_if.sv
// Handshake/data bundle between the mode controller (master) and the
// permutation core (slave).
// - i_start      : request a permutation (sampled only while idle)
// - i_num_rounds : round count n
// - i_state      : input state, captured with an accepted start
// - o_state      : state register, result valid when o_valid=1
// - o_busy       : rounds executing
// - o_valid      : one-cycle completion pulse
// - o_error      : one-cycle pulse on a rejected start (illegal n)
interface ascon_permutation_if;
    import ascon_pkg::*;

    logic         i_start;
    logic [3:0]   i_num_rounds;
    t_state_array i_state;
    t_state_array o_state;
    logic         o_busy;
    logic         o_valid;
    logic         o_error;

    modport master (
        output i_start, i_num_rounds, i_state,
        input  o_state, o_busy, o_valid, o_error
    );

    modport slave (
        input  i_start, i_num_rounds, i_state,
        output o_state, o_busy, o_valid, o_error
    );

endinterface

// File: rtl/permutation_round.sv
// One complete, purely combinational Ascon round:
// constant addition -> substitution layer -> linear diffusion.
// - i_state : state before the round
// - i_round : round index r (0..11) selecting c[r]
// - o_state : state after the round
module permutation_round
    import ascon_pkg::*;
#(
    parameter int unsigned G_NUM_SBOXES = 64
) (
    input  t_state_array i_state,
    input  logic [3:0]   i_round,
    output t_state_array o_state
);

    t_state_array state_c;
    t_state_array state_s;

    always_comb begin
        state_c          = i_state;
        state_c[2][7:0]  = i_state[2][7:0] ^ round_const(i_round);
    end

    substitution_layer #(
        .G_NUM_SBOXES (G_NUM_SBOXES)
    ) u_sbox (
        .i_x (state_c),
        .o_x (state_s)
    );

    for (genvar w = 0; w < C_NUM_WORDS; w++) begin : g_lin
        assign o_state[w] = state_s[w]
                          ^ ror64(state_s[w], C_ROT_A[w])
                          ^ ror64(state_s[w], C_ROT_B[w]);
    end

endmodule

// File: rtl/substitution_layer.sv
// Ascon substitution layer: one 5-bit S-box per bit column.
// - i_x : 5 words of G_NUM_SBOXES bits, column i = {x0[i], x1[i], x2[i], x3[i], x4[i]}
// - o_x : substituted words, same layout
module substitution_layer
    import ascon_pkg::*;
#(
    parameter int unsigned G_NUM_SBOXES = 64
) (
    input  logic [C_NUM_WORDS-1:0][G_NUM_SBOXES-1:0] i_x,
    output logic [C_NUM_WORDS-1:0][G_NUM_SBOXES-1:0] o_x
);

    for (genvar i = 0; i < G_NUM_SBOXES; i++) begin : g_col
        logic [4:0] col_in;
        logic [4:0] col_out;

        assign col_in    = {i_x[0][i], i_x[1][i], i_x[2][i], i_x[3][i], i_x[4][i]};
        assign col_out   = sbox5(col_in);
        assign o_x[0][i] = col_out[4];
        assign o_x[1][i] = col_out[3];
        assign o_x[2][i] = col_out[2];
        assign o_x[3][i] = col_out[1];
        assign o_x[4][i] = col_out[0];
    end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation p^n with registered state.
// - i_clk, i_rst : clock (rising edge), synchronous active-high reset
// - bus          : slave side of ascon_permutation_if (start/valid handshake,
//                  input state, result state, busy and error flags)
// G_ROUNDS_PER_CYCLE (1 or 2) round instances are chained per clock; the round
// index starts at 12-n so every run ends on index 11.
module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int unsigned G_ROUNDS_PER_CYCLE = 1,
    parameter int unsigned G_NUM_SBOXES       = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ascon_permutation_if.slave  bus
);

    t_perm_fsm    fsm_q,   fsm_d;
    logic [3:0]   round_q, round_d;
    t_state_array state_q, state_d;
    logic         valid_q, valid_d;
    logic         error_q, error_d;

    t_state_array round_io [G_ROUNDS_PER_CYCLE+1];

    assign round_io[0] = state_q;

    for (genvar g = 0; g < G_ROUNDS_PER_CYCLE; g++) begin : g_round
        permutation_round #(
            .G_NUM_SBOXES (G_NUM_SBOXES)
        ) u_round (
            .i_state (round_io[g]),
            .i_round (round_q + 4'(g)),
            .o_state (round_io[g+1])
        );
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (legal_rounds(bus.i_num_rounds, G_ROUNDS_PER_CYCLE)) begin
                        fsm_d   = RUN;
                        round_d = 4'(C_MAX_ROUNDS) - bus.i_num_rounds;
                        state_d = bus.i_state;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                state_d = round_io[G_ROUNDS_PER_CYCLE];
                round_d = round_q + 4'(G_ROUNDS_PER_CYCLE);
                if (round_d == 4'(C_MAX_ROUNDS)) begin
                    fsm_d   = IDLE;
                    valid_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign bus.o_state = state_q;
    assign bus.o_busy  = (fsm_q == RUN);
    assign bus.o_valid = valid_q;
    assign bus.o_error = error_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Directed bench for ascon_permutation: a G=1 and a G=2 instance on a shared
// clock/reset, checked against a bit-sliced reference of the Ascon round.
module tb_ascon_permutation;
    import ascon_pkg::*;

    logic i_clk;
    logic i_rst;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    ascon_permutation_if bus1 ();
    ascon_permutation_if bus2 ();

    ascon_permutation #(.G_ROUNDS_PER_CYCLE(1), .G_NUM_SBOXES(64)) dut1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus1)
    );

    ascon_permutation #(.G_ROUNDS_PER_CYCLE(2), .G_NUM_SBOXES(64)) dut2 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus2)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (ascon-c style bit-sliced round) -------
    function automatic logic [63:0] rr(input logic [63:0] x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

    function automatic t_state_array ref_perm(input t_state_array s_in, input int n);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        t_state_array s_out;
        x0 = s_in[0]; x1 = s_in[1]; x2 = s_in[2]; x3 = s_in[3]; x4 = s_in[4];
        for (int r = 12 - n; r < 12; r++) begin
            x2 = x2 ^ 64'(240 - 15 * r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
            x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
            x2 = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
            x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
            x4 = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
        end
        s_out[0] = x0; s_out[1] = x1; s_out[2] = x2; s_out[3] = x3; s_out[4] = x4;
        return s_out;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // ---------------- stimulus helpers (no checking) -------------------------
    task automatic drive(input int which, input logic st, input logic [3:0] n, input t_state_array s);
        if (which == 1) begin
            bus1.i_start = st; bus1.i_num_rounds = n; bus1.i_state = s;
        end else begin
            bus2.i_start = st; bus2.i_num_rounds = n; bus2.i_state = s;
        end
    endtask

    // Starts a run and observes it for a fixed window. lat is the number of
    // edges after the start edge at which o_valid is first seen (-1 if never).
    // extra_at >= 0 pulses i_start once more (different state) at that offset.
    task automatic run_perm(input int which, input t_state_array s, input logic [3:0] n,
                            input int extra_at, output int lat, output int busy_cycles,
                            output int valid_pulses, output t_state_array res);
        logic b, v;
        lat = -1; busy_cycles = 0; valid_pulses = 0; res = '0;
        @(negedge i_clk);
        drive(which, 1'b1, n, s);
        @(negedge i_clk);
        drive(which, 1'b0, n, s);
        for (int k = 0; k < 30; k++) begin
            if (k == extra_at)     drive(which, 1'b1, n, ~s);
            if (k == extra_at + 1) drive(which, 1'b0, n, s);
            b = (which == 1) ? bus1.o_busy  : bus2.o_busy;
            v = (which == 1) ? bus1.o_valid : bus2.o_valid;
            if (b) busy_cycles++;
            if (v) begin
                valid_pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = (which == 1) ? bus1.o_state : bus2.o_state;
                end
            end
            @(negedge i_clk);
        end
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        i_rst = 1'b1;
        drive(1, 1'b0, 4'd0, '0);
        drive(2, 1'b0, 4'd0, '0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            total++;
            if (bus1.o_state !== '0 || bus1.o_busy !== 1'b0 || bus1.o_valid !== 1'b0 || bus1.o_error !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle c=%0d: got busy=%b valid=%b err=%b state_nz=%b want all zero",
                         c, bus1.o_busy, bus1.o_valid, bus1.o_error, |bus1.o_state);
            end
        end
    endtask

    task automatic test_p12_zero();
        int lat, busy, vp;
        t_state_array res, exp_s;
        exp_s = ref_perm('0, 12);
        run_perm(1, '0, 4'd12, -1, lat, busy, vp, res);
        total++; if (lat !== 12) begin bad++; $display("FAIL p12_latency: got %0d want 12", lat); end
        total++; if (busy !== 12) begin bad++; $display("FAIL p12_busy: got %0d want 12", busy); end
        total++; if (vp !== 1) begin bad++; $display("FAIL p12_valid_count: got %0d want 1", vp); end
        total++; if (res !== exp_s) begin bad++; $display("FAIL p12_result: got %h want %h", res, exp_s); end
        total++; if (bus1.o_state !== exp_s) begin bad++; $display("FAIL p12_hold: got %h want %h", bus1.o_state, exp_s); end
    endtask

    task automatic test_p6_p8();
        int lat, busy, vp;
        t_state_array s, res, exp_s;
        logic [3:0] ns [2] = '{4'd6, 4'd8};
        for (int i = 0; i < 2; i++) begin
            s = rand_state();
            exp_s = ref_perm(s, int'(ns[i]));
            run_perm(1, s, ns[i], -1, lat, busy, vp, res);
            total++; if (lat !== int'(ns[i])) begin bad++; $display("FAIL p%0d_latency: got %0d want %0d", ns[i], lat, ns[i]); end
            total++; if (busy !== int'(ns[i])) begin bad++; $display("FAIL p%0d_busy: got %0d want %0d", ns[i], busy, ns[i]); end
            total++; if (res !== exp_s) begin bad++; $display("FAIL p%0d_result: got %h want %h", ns[i], res, exp_s); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, busy, vp;
        t_state_array s, res, exp_s;
        s = rand_state();
        exp_s = ref_perm(s, 12);
        run_perm(1, s, 4'd12, 3, lat, busy, vp, res);
        total++; if (lat !== 12) begin bad++; $display("FAIL busy_start_latency: got %0d want 12", lat); end
        total++; if (vp !== 1) begin bad++; $display("FAIL busy_start_valid_count: got %0d want 1", vp); end
        total++; if (res !== exp_s) begin bad++; $display("FAIL busy_start_result: got %h want %h", res, exp_s); end
    endtask

    task automatic test_illegal();
        logic [3:0] bad_n [5] = '{4'd0, 4'd5, 4'd10, 4'd13, 4'd15};
        t_state_array prev;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            prev = bus1.o_state;
            drive(1, 1'b1, bad_n[i], rand_state());
            @(negedge i_clk);
            drive(1, 1'b0, bad_n[i], '0);
            total++;
            if (bus1.o_error !== 1'b1 || bus1.o_busy !== 1'b0) begin
                bad++;
                $display("FAIL illegal_n%0d_pulse: got err=%b busy=%b want err=1 busy=0", bad_n[i], bus1.o_error, bus1.o_busy);
            end
            @(negedge i_clk);
            total++;
            if (bus1.o_error !== 1'b0 || bus1.o_busy !== 1'b0) begin
                bad++;
                $display("FAIL illegal_n%0d_after: got err=%b busy=%b want err=0 busy=0", bad_n[i], bus1.o_error, bus1.o_busy);
            end
            total++;
            if (bus1.o_state !== prev) begin
                bad++;
                $display("FAIL illegal_n%0d_state: got %h want %h", bad_n[i], bus1.o_state, prev);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, busy, vp, seen;
        t_state_array s, res, exp_s;
        s = rand_state();
        @(negedge i_clk);
        drive(1, 1'b1, 4'd12, s);
        @(negedge i_clk);
        drive(1, 1'b0, 4'd12, s);
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        total++;
        if (bus1.o_state !== '0 || bus1.o_busy !== 1'b0 || bus1.o_valid !== 1'b0 || bus1.o_error !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: got busy=%b valid=%b err=%b state_nz=%b want all zero",
                     bus1.o_busy, bus1.o_valid, bus1.o_error, |bus1.o_state);
        end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge i_clk);
            if (bus1.o_valid || bus1.o_busy) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_valid: got %0d active cycles want 0", seen); end
        s = rand_state();
        exp_s = ref_perm(s, 8);
        run_perm(1, s, 4'd8, -1, lat, busy, vp, res);
        total++; if (lat !== 8) begin bad++; $display("FAIL midrst_restart_latency: got %0d want 8", lat); end
        total++; if (res !== exp_s) begin bad++; $display("FAIL midrst_restart_result: got %h want %h", res, exp_s); end
    endtask

    task automatic test_g2();
        int lat, busy, vp;
        t_state_array s, res, exp_s;
        logic [3:0] ns [3] = '{4'd12, 4'd6, 4'd8};
        for (int i = 0; i < 3; i++) begin
            s = (i == 0) ? t_state_array'('0) : rand_state();
            exp_s = ref_perm(s, int'(ns[i]));
            run_perm(2, s, ns[i], -1, lat, busy, vp, res);
            total++; if (lat !== int'(ns[i]) / 2) begin bad++; $display("FAIL g2_p%0d_latency: got %0d want %0d", ns[i], lat, ns[i] / 2); end
            total++; if (busy !== int'(ns[i]) / 2) begin bad++; $display("FAIL g2_p%0d_busy: got %0d want %0d", ns[i], busy, ns[i] / 2); end
            total++; if (vp !== 1) begin bad++; $display("FAIL g2_p%0d_valid_count: got %0d want 1", ns[i], vp); end
            total++; if (res !== exp_s) begin bad++; $display("FAIL g2_p%0d_result: got %h want %h", ns[i], res, exp_s); end
        end
    endtask

    task automatic test_back_to_back();
        int k, lat, vp;
        t_state_array sa, sb, exp_a, exp_b, res;
        sa = rand_state();
        sb = rand_state();
        exp_a = ref_perm(sa, 8);
        exp_b = ref_perm(sb, 6);
        @(negedge i_clk);
        drive(1, 1'b1, 4'd8, sa);
        @(negedge i_clk);
        drive(1, 1'b0, 4'd8, sa);
        k = 0;
        while (!bus1.o_valid && k < 30) begin
            @(negedge i_clk);
            k++;
        end
        total++; if (k !== 8) begin bad++; $display("FAIL b2b_first_latency: got %0d want 8", k); end
        total++; if (bus1.o_state !== exp_a) begin bad++; $display("FAIL b2b_first_result: got %h want %h", bus1.o_state, exp_a); end
        drive(1, 1'b1, 4'd6, sb);
        @(negedge i_clk);
        drive(1, 1'b0, 4'd6, sb);
        total++;
        if (bus1.o_valid !== 1'b0 || bus1.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: got valid=%b busy=%b want valid=0 busy=1", bus1.o_valid, bus1.o_busy);
        end
        lat = -1; vp = 0; res = '0;
        for (int j = 0; j < 20; j++) begin
            if (bus1.o_valid) begin
                vp++;
                if (lat < 0) begin lat = j; res = bus1.o_state; end
            end
            @(negedge i_clk);
        end
        total++; if (lat !== 6) begin bad++; $display("FAIL b2b_second_latency: got %0d want 6", lat); end
        total++; if (vp !== 1) begin bad++; $display("FAIL b2b_second_valid_count: got %0d want 1", vp); end
        total++; if (res !== exp_b) begin bad++; $display("FAIL b2b_second_result: got %h want %h", res, exp_b); end
    endtask

    initial begin
        test_reset();
        test_p12_zero();
        test_p6_p8();
        test_start_while_busy();
        test_illegal();
        test_reset_mid_run();
        test_g2();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
